diff_drive_mixer: RTL
=====================

// Module: diff_drive_mixer
// PURPOSE
//  Parametrised differential-drive mixer for the BB8 stepper chain. Takes a pitch/yaw
//  command from bluetooth_wrapper (or the control loop) and mixes it into NUM_CH signed
//  channel targets. Each channel is ramp-limited with a direction-reversal dwell and emits
//  magnitude + dir to one MotorDriver. Replaces the combinational pitch/yaw->motor glue.
// PARAMETERS
//  NUM_CH      2     number of motor channels (>=1)
//  IN_W        9     width of signed cmd_pitch / cmd_yaw
//  SPD_W       10    width of unsigned speed magnitude output
//  MAX_SPEED   500   saturation limit on |target|, must be < 2**SPD_W
//  YAW_SIGN    2'b10 per-channel bit: 0 -> target=pitch+yaw, 1 -> target=pitch-yaw
//  ACCEL_STEP  4     max |speed| change per ramp tick
//  RAMP_DIV    1000  clock cycles per ramp tick (>=1)
//  DIR_DWELL   8     ramp ticks held at zero before a direction reversal
//  WD_CYCLES   50_000_000  command watchdog timeout (used only with the macro below)
// PORTS
//  clock      in   1              system clock (CLOCK_100)
//  reset      in   1              asynchronous, active-high reset
//  enable     in   1              0 -> all targets forced to 0 (ramp down, not cut)
//  cmd_valid  in   1              one-cycle strobe; latch cmd_pitch/cmd_yaw
//  cmd_pitch  in   IN_W           signed forward command
//  cmd_yaw    in   IN_W           signed turn command
//  speed      out  NUM_CH*SPD_W   per-channel |current speed|, channel i at [i*SPD_W +: SPD_W]
//  dir        out  NUM_CH         per-channel direction, 1 = forward
//  moving     out  1              OR of (speed[i] != 0)
//  wd_expired out  1              watchdog fired; 0 when macro absent
// BEHAVIOUR
//  Reset (async assert): speed=0, dir=all 1, moving=0, wd_expired=0, latched cmd=0,
//    tick counter=0, all channels in IDLE.
//  Command latch: on cmd_valid, register pitch/yaw. Targets update the following cycle.
//    A new cmd_valid overwrites the latched command. No ready; every strobe is accepted.
//  Mix: t_i = pitch +/- yaw in IN_W+1 bits, saturated to [-MAX_SPEED, +MAX_SPEED].
//    enable=0 overrides t_i to 0.
//  Tick: free-running counter 0..RAMP_DIV-1; tick pulses when it wraps. All channels
//    update only on tick.
//  Channel FSM (signed cur_i, SPD_W+1 bits):
//    IDLE : cur=0. If t!=0 and sign(t) matches dir -> RAMP.
//           If t!=0 and sign differs -> DWELL with dwell count cleared.
//    RAMP : each tick, cur moves toward t by min(ACCEL_STEP, |t-cur|).
//           If sign(t) opposes cur, ramp toward 0 only; never cross zero.
//           When cur reaches 0 -> IDLE.
//    DWELL: cur=0. Count ticks. After DIR_DWELL ticks, flip dir -> RAMP.
//           If t returns to 0 or matches the old dir -> IDLE, and dir is unchanged.
//  Outputs are registered: speed_i=|cur_i|, dir_i from FSM. dir only changes while speed_i=0.
//  Latency: cmd_valid -> first speed change is at most 2 + RAMP_DIV cycles.
//  Boundaries: t_i == cur_i: hold. t_i == 0 and cur_i == 0: stay IDLE, dir held.
//    Saturation is exact at +/-MAX_SPEED, with no wrap. Reset mid-ramp zeroes at once
//    (motors are expected de-energised by MotorDriver on reset).
// CONFIGURATION
//  DIFF_DRIVE_MIXER_WATCHDOG_EN defined:
//    - Counter clears on cmd_valid. Reaching WD_CYCLES sets wd_expired and forces all t_i=0
//      (normal ramp-down).
//    - The next cmd_valid clears wd_expired and restarts the counter.
//  Macro undefined: no counter; wd_expired tied 0; last command held indefinitely.
// STRUCTURE
//  drive_pkg: typedef chan_state_e {IDLE, RAMP, DWELL}; saturate/abs helper functions;
//    type aliases for the speed width.
//  Sub-module speed_ramp_ch: one channel FSM + cur/dwell registers. Instantiated NUM_CH
//    times in a generate loop. Top holds cmd latch, mixer, tick divider, watchdog.
// TESTING (bench uses RAMP_DIV=4, ACCEL_STEP=4, DIR_DWELL=2, MAX_SPEED=500 unless stated)
//  1. Reset mid-ramp (speed=40) -> same-cycle async clear: speed=0, dir=11, moving=0.
//  2. cmd pitch=100, yaw=0 -> both speeds 4,8,..,100 on successive ticks; dir=11;
//     then hold at 100.
//  3. pitch=0, yaw=50 -> ch0 ramps to +50; ch1 drops to 0, dwells 2 ticks, dir1=0,
//     then ramps to 50.
//  4. pitch=255, yaw=255 (IN_W=9) -> ch0 saturates at 500, ch1 target 0; no wrap.
//  5. Running at 100, enable=0 -> 4-per-tick ramp to 0; dir unchanged; moving falls at 0.
//  6. WATCHDOG_EN, WD_CYCLES=100: no cmd for 100 cycles -> wd_expired=1, ramp to 0;
//     next cmd_valid clears it.

Source files
------------

// File: rtl/drive_pkg.sv
// drive_pkg: shared types and helpers for the differential-drive mixer.
//   chan_state_e  : per-channel ramp FSM states (IDLE, RAMP, DWELL)
//   speed_t/cur_t : speed-magnitude and signed-speed aliases at the default width
//   sat_i         : symmetric saturation of a signed value to [-lim, +lim]
//   abs_i         : absolute value
//   step_toward   : move a value toward a target by at most 'step'
package drive_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      DWELL = 2'd2
   } chan_state_e;

   localparam int DEF_SPD_W = 10;

   typedef logic        [DEF_SPD_W-1:0] speed_t;
   typedef logic signed [DEF_SPD_W:0]   cur_t;

   function automatic int sat_i(input int v, input int lim);
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      else
         return v;
   endfunction

   function automatic int abs_i(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int step_toward(input int cur, input int tgt, input int step);
      int d;
      d = tgt - cur;
      if (d > step)
         return cur + step;
      else if (d < -step)
         return cur - step;
      else
         return tgt;
   endfunction

endpackage

// File: rtl/speed_ramp_ch.sv
// speed_ramp_ch: one ramp-limited motor channel with direction-reversal dwell.
//   clock  : system clock
//   reset  : asynchronous active-high reset (cur=0, dir=1, IDLE)
//   tick   : ramp tick strobe; state only advances when high
//   target : signed target speed (SPD_W+1 bits, already saturated)
//   speed  : |cur|, derived from the cur register only
//   dir    : current direction, 1 = forward; only changes while cur = 0
module speed_ramp_ch
   import drive_pkg::*;
#(
   parameter int SPD_W      = 10,
   parameter int ACCEL_STEP = 4,
   parameter int DIR_DWELL  = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    tick,
   input  logic signed [SPD_W:0]   target,
   output logic        [SPD_W-1:0] speed,
   output logic                    dir
);

   localparam int CW = SPD_W + 1;
   localparam int DW = (DIR_DWELL > 1) ? $clog2(DIR_DWELL + 1) : 1;

   chan_state_e             state, state_n;
   logic signed [SPD_W:0]   cur, cur_n;
   logic                    dir_n;
   logic        [DW-1:0]    dwell_cnt, dwell_n;

   int   tv, cv, ev, nv, av;
   logic match;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cur       <= '0;
         dir       <= 1'b1;
         dwell_cnt <= '0;
      end else begin
         state     <= state_n;
         cur       <= cur_n;
         dir       <= dir_n;
         dwell_cnt <= dwell_n;
      end
   end

   always_comb begin
      state_n = state;
      cur_n   = cur;
      dir_n   = dir;
      dwell_n = dwell_cnt;
      tv      = int'(target);
      cv      = int'(cur);
      ev      = 0;
      nv      = cv;
      // Target agrees with the current direction (zero never agrees).
      match   = dir ? (tv > 0) : (tv < 0);

      if (tick) begin
         case (state)
            IDLE: begin
               cur_n = '0;
               // Step on the same tick we leave IDLE so the first speed change
               // lands within one tick period of a new command.
               if (match) begin
                  nv      = step_toward(0, tv, ACCEL_STEP);
                  cur_n   = CW'(nv);
                  state_n = RAMP;
               end else if (tv != 0) begin
                  dwell_n = '0;
                  state_n = DWELL;
               end
            end
            RAMP: begin
               // An opposing or zero target only pulls cur to zero; the
               // reversal itself goes through IDLE and DWELL.
               ev    = match ? tv : 0;
               nv    = step_toward(cv, ev, ACCEL_STEP);
               cur_n = CW'(nv);
               if (nv == 0)
                  state_n = IDLE;
            end
            DWELL: begin
               cur_n = '0;
               if (tv == 0 || match) begin
                  dwell_n = '0;
                  state_n = IDLE;
               end else if (int'(dwell_cnt) + 1 >= DIR_DWELL) begin
                  dwell_n = '0;
                  dir_n   = ~dir;
                  state_n = RAMP;
               end else begin
                  dwell_n = dwell_cnt + DW'(1);
               end
            end
            default: begin
               cur_n   = '0;
               dwell_n = '0;
               state_n = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      av    = abs_i(int'(cur));
      speed = SPD_W'(av);
   end

endmodule

// File: rtl/diff_drive_mixer.sv
// diff_drive_mixer: pitch/yaw command latch, per-channel mixer with saturation,
// ramp tick divider, optional command watchdog, and NUM_CH ramp channels.
// Optional feature: define DIFF_DRIVE_MIXER_WATCHDOG_EN to enable the command
// watchdog; without it wd_expired is tied low and the last command holds forever.
//   clock      : system clock
//   reset      : asynchronous active-high reset
//   enable     : 0 forces every target to zero (channels ramp down)
//   cmd_valid  : one-cycle strobe latching cmd_pitch/cmd_yaw
//   cmd_pitch  : signed forward command
//   cmd_yaw    : signed turn command
//   speed      : per-channel |speed|, channel i at [i*SPD_W +: SPD_W]
//   dir        : per-channel direction, 1 = forward
//   moving     : any channel speed nonzero
//   wd_expired : command watchdog timed out
//
// Handshake: cmd_valid is a bare strobe with no ready; every strobe is accepted
// and overwrites the latched command, which drives the targets the next cycle.
module diff_drive_mixer
   import drive_pkg::*;
#(
   parameter int                NUM_CH     = 2,
   parameter int                IN_W       = 9,
   parameter int                SPD_W      = 10,
   parameter int                MAX_SPEED  = 500,
   parameter logic [NUM_CH-1:0] YAW_SIGN   = 2'b10,
   parameter int                ACCEL_STEP = 4,
   parameter int                RAMP_DIV   = 1000,
   parameter int                DIR_DWELL  = 8,
   parameter int                WD_CYCLES  = 50_000_000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      cmd_valid,
   input  logic signed [IN_W-1:0]    cmd_pitch,
   input  logic signed [IN_W-1:0]    cmd_yaw,
   output logic [NUM_CH*SPD_W-1:0]   speed,
   output logic [NUM_CH-1:0]         dir,
   output logic                      moving,
   output logic                      wd_expired
);

   localparam int CW = SPD_W + 1;
   localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);

   if (NUM_CH < 1 || RAMP_DIV < 1 || WD_CYCLES < 1 || MAX_SPEED >= 2 ** SPD_W) begin : g_bad_params
      $error("diff_drive_mixer: illegal parameter combination");
   end

   logic signed [IN_W-1:0] pitch_q, yaw_q;
   logic        [TW-1:0]   tick_cnt;
   logic                   tick;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pitch_q <= '0;
         yaw_q   <= '0;
      end else if (cmd_valid) begin
         pitch_q <= cmd_pitch;
         yaw_q   <= cmd_yaw;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TW'(1);
   end

`ifdef DIFF_DRIVE_MIXER_WATCHDOG_EN
   localparam int WW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
   localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);

   logic [WW-1:0] wd_cnt;

   // The counter freezes once expired; only a new command restarts it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt     <= '0;
         wd_expired <= 1'b0;
      end else if (cmd_valid) begin
         wd_cnt     <= '0;
         wd_expired <= 1'b0;
      end else if (!wd_expired) begin
         if (wd_cnt == WD_LAST)
            wd_expired <= 1'b1;
         else
            wd_cnt <= wd_cnt + WW'(1);
      end
   end
`else
   assign wd_expired = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic signed [SPD_W:0] tgt;
      int                    mix;

      // The IN_W+1-bit sum is exact in int; saturation clamps before the
      // narrowing cast, so no wrap is possible.
      always_comb begin
         mix = YAW_SIGN[i] ? (int'(pitch_q) - int'(yaw_q))
                           : (int'(pitch_q) + int'(yaw_q));
         tgt = CW'(sat_i(mix, MAX_SPEED));
         if (!enable || wd_expired)
            tgt = '0;
      end

      speed_ramp_ch #(
         .SPD_W      (SPD_W),
         .ACCEL_STEP (ACCEL_STEP),
         .DIR_DWELL  (DIR_DWELL)
      ) u_ch (
         .clock  (clock),
         .reset  (reset),
         .tick   (tick),
         .target (tgt),
         .speed  (speed[i*SPD_W +: SPD_W]),
         .dir    (dir[i])
      );
   end

   assign moving = |speed;

endmodule
